// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared FSM state encoding and default width for the bit-serial adder.
package serial_adder_pkg;
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, DONE = 2'b10} state_t;
  localparam int DEFAULT_WIDTH = 8;
endpackage

// File: rtl/fa_cell.sv
// fa_cell: combinational 1-bit full adder.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial add/subtract engine, one bit per cycle LSB first,
// with valid/ready command and result handshakes.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             sub,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH);

  state_t state, next;
  logic [WIDTH-1:0] reg_a, reg_b, res_sh;
  logic [CW-1:0] bit_cnt;
  logic carry, c_msb_in, s, c, last, pen;

  fa_cell u_fa (.a(reg_a[0]), .b(reg_b[0]), .cin(carry), .s(s), .cout(c));

  assign last = bit_cnt == CW'(WIDTH - 1);
  assign pen  = bit_cnt == CW'(WIDTH - 2);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= next;

  always_comb begin
    next = state;
    case (state)
      IDLE:    next = start_valid ? RUN : IDLE;
      RUN:     next = last ? DONE : RUN;
      DONE:    next = res_ready ? IDLE : DONE;
      default: next = IDLE;
    endcase
  end

  always_comb begin
    start_ready = state == IDLE;
    busy        = state == RUN;
    res_valid   = state == DONE;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      reg_a     <= '0;
      reg_b     <= '0;
      res_sh    <= '0;
      bit_cnt   <= '0;
      carry     <= 1'b0;
      c_msb_in  <= 1'b0;
      sum       <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else if (start_valid && start_ready) begin
      reg_a   <= op_a;
      reg_b   <= sub ? ~op_b : op_b;
      carry   <= sub;
      bit_cnt <= '0;
    end else if (busy) begin
      reg_a   <= reg_a >> 1;
      reg_b   <= reg_b >> 1;
      res_sh  <= {s, res_sh[WIDTH-1:1]};
      carry   <= c;
      bit_cnt <= bit_cnt + CW'(1);
      // carry out of bit WIDTH-2 is the carry into the MSB
      if (pen) c_msb_in <= c;
      if (last) begin
        sum       <= {s, res_sh[WIDTH-1:1]};
        carry_out <= c;
        overflow  <= c_msb_in ^ c;
      end
    end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: scoreboard bench for serial_adder_ctrl at WIDTH=8.
module tb_serial_adder_ctrl;
  localparam int W = 8;
  typedef struct packed {logic [W-1:0] sum; logic co; logic ov;} res_t;

  logic clk = 1'b0, rst_n = 1'b0, start_valid = 1'b0, sub = 1'b0, res_ready = 1'b0;
  logic start_ready, res_valid, carry_out, overflow, busy;
  logic [W-1:0] op_a = '0, op_b = '0, sum;
  res_t sb[$];
  int total = 0, bad = 0;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(start_ready),
    .op_a(op_a), .op_b(op_b), .sub(sub), .res_valid(res_valid), .res_ready(res_ready),
    .sum(sum), .carry_out(carry_out), .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    res_t r;
    int ur, sr;
    ur = s ? int'(a) - int'(b) : int'(a) + int'(b);
    sr = s ? int'($signed(a)) - int'($signed(b)) : int'($signed(a)) + int'($signed(b));
    r.sum = W'(ur);
    r.co = s ? (a >= b) : (ur >= (1 << W));
    r.ov = (sr > (1 << (W - 1)) - 1) || (sr < -(1 << (W - 1)));
    return r;
  endfunction

  // entered just after a falling edge; returns at a falling edge with the engine idle
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       output res_t got, output int lat, output int bc);
    op_a = a; op_b = b; sub = s; start_valid = 1'b1;
    @(posedge clk);
    #1 start_valid = 1'b0;
    lat = 0; bc = 0;
    forever begin
      @(negedge clk);
      if (res_valid || lat >= 100) break;
      if (busy) bc++;
      @(posedge clk);
      lat++;
    end
    got = {sum, carry_out, overflow};
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [12:0] o;
    repeat (2) @(negedge clk);
    o = {start_ready, res_valid, busy, sum, carry_out, overflow};
    total++;
    if (o !== 13'h1000) begin bad++; $display("FAIL reset_held: got %h want 1000", o); end
    rst_n = 1'b1;
    @(negedge clk);
    o = {start_ready, res_valid, busy, sum, carry_out, overflow};
    total++;
    if (o !== 13'h1000) begin bad++; $display("FAIL reset_released: got %h want 1000", o); end
  endtask

  task automatic test_directed();
    logic [W-1:0] ta[5] = '{8'h05, 8'hFF, 8'h7F, 8'h03, 8'h80};
    logic [W-1:0] tb[5] = '{8'h03, 8'h01, 8'h01, 8'h05, 8'h01};
    logic ts[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [9:0] te[5] = '{10'h020, 10'h002, 10'h201, 10'h3F8, 10'h1FF};
    res_t got, exp;
    int lat, bc;
    for (int i = 0; i < 5; i++) begin
      sb.push_back(res_t'(te[i]));
      do_op(ta[i], tb[i], ts[i], got, lat, bc);
      exp = sb.pop_front();
      total++;
      if (got !== exp || lat != 8 || bc != 8) begin
        bad++;
        $display("FAIL directed%0d: got sum=%h co=%b ov=%b lat=%0d busy=%0d, want sum=%h co=%b ov=%b lat=8 busy=8",
                 i, got.sum, got.co, got.ov, lat, bc, exp.sum, exp.co, exp.ov);
      end
    end
  endtask

  task automatic test_backpressure();
    res_t got, exp;
    int n;
    sb.push_back(model(8'h9C, 8'h27, 1'b1));
    op_a = 8'h9C; op_b = 8'h27; sub = 1'b1; start_valid = 1'b1;
    @(posedge clk);
    #1 start_valid = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!res_valid && n < 100);
    exp = sb.pop_front();
    op_a = 8'h11; op_b = 8'h22; sub = 1'b0; start_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      got = {sum, carry_out, overflow};
      total++;
      if (got !== exp || start_ready !== 1'b0 || res_valid !== 1'b1) begin
        bad++;
        $display("FAIL bp_hold%0d: got sum=%h co=%b ov=%b rdy=%b vld=%b, want sum=%h co=%b ov=%b rdy=0 vld=1",
                 i, got.sum, got.co, got.ov, start_ready, res_valid, exp.sum, exp.co, exp.ov);
      end
      @(negedge clk);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    total++;
    if ({start_ready, res_valid, busy} !== 3'b100 || {sum, carry_out, overflow} !== exp) begin
      bad++;
      $display("FAIL bp_release: got rdy/vld/busy=%b sum=%h, want 100 sum=%h", {start_ready, res_valid, busy}, sum, exp.sum);
    end
    sb.push_back(model(8'h11, 8'h22, 1'b0));
    @(posedge clk);
    #1 start_valid = 1'b0;
    @(negedge clk);
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL bp_accept: got busy=%b want 1", busy); end
    n = 0;
    while (!res_valid && n < 100) begin @(negedge clk); n++; end
    got = {sum, carry_out, overflow};
    exp = sb.pop_front();
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL bp_next: got sum=%h co=%b ov=%b, want sum=%h co=%b ov=%b", got.sum, got.co, got.ov, exp.sum, exp.co, exp.ov);
    end
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    logic [12:0] o;
    res_t got, exp;
    int lat, bc;
    op_a = 8'hAA; op_b = 8'h55; sub = 1'b0; start_valid = 1'b1;
    @(posedge clk);
    #1 start_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 o = {start_ready, res_valid, busy, sum, carry_out, overflow};
    total++;
    if (o !== 13'h1000) begin bad++; $display("FAIL reset_mid_run: got %h want 1000", o); end
    @(negedge clk);
    rst_n = 1'b1;
    sb.push_back(res_t'(10'h118));
    do_op(8'h12, 8'h34, 1'b0, got, lat, bc);
    exp = sb.pop_front();
    total++;
    if (got !== exp || lat != 8) begin
      bad++;
      $display("FAIL after_reset: got sum=%h co=%b ov=%b lat=%0d, want sum=%h co=%b ov=%b lat=8",
               got.sum, got.co, got.ov, lat, exp.sum, exp.co, exp.ov);
    end
  endtask

  task automatic test_truth_table();
    res_t got, exp;
    int lat, bc;
    for (int k = 0; k < 32; k++) begin
      sb.push_back(model(W'(k & 3), W'((k >> 2) & 3), k[4]));
      do_op(W'(k & 3), W'((k >> 2) & 3), k[4], got, lat, bc);
      exp = sb.pop_front();
      total++;
      if (got !== exp || lat != 8) begin
        bad++;
        $display("FAIL truth%0d: got sum=%h co=%b ov=%b lat=%0d, want sum=%h co=%b ov=%b lat=8",
                 k, got.sum, got.co, got.ov, lat, exp.sum, exp.co, exp.ov);
      end
    end
  endtask

  task automatic test_back_to_back();
    res_t got, exp;
    int lat, bc;
    logic [W-1:0] a, b;
    logic s;
    for (int i = 0; i < 200; i++) begin
      a = W'($urandom); b = W'($urandom); s = 1'($urandom);
      sb.push_back(model(a, b, s));
      do_op(a, b, s, got, lat, bc);
      exp = sb.pop_front();
      total++;
      if (got !== exp || lat != 8 || bc != 8) begin
        bad++;
        $display("FAIL random%0d %h%s%h: got sum=%h co=%b ov=%b lat=%0d, want sum=%h co=%b ov=%b lat=8",
                 i, a, s ? "-" : "+", b, got.sum, got.co, got.ov, lat, exp.sum, exp.co, exp.ov);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_run();
    test_truth_table();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
